// File: rtl/reg_mem_transfer.sv
// ---------------------------------------------------------------------------
// reg_mem_transfer
//
// Bulk transfer sequencer for CHIP-8 FX55 / FX65. It moves V0..Vx between
// the register file and a single-port synchronous RAM, one byte per cycle,
// starting at memory address I. It optionally advances I to I + x + 1 when
// the transfer completes. While busy it owns the register-file Vx port, the
// I write port and the RAM port.
//
// Parameters
//   INCR_I  1: write I = I + x + 1 in the DONE cycle; 0: leave I untouched
//   ADDR_W  memory address width (must be >= 4)
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   i_start        request pulse, only honoured in IDLE
//   i_load         1 = FX65 (memory -> registers), 0 = FX55 (registers -> memory)
//   i_x            last register index, V0..Vx inclusive
//   i_i_data       current I value, captured with i_start
//   o_busy         high from the cycle after an accepted start through DONE
//   o_done         one-cycle completion pulse
//   o_vx_addr      register-file index (read for store, write for load)
//   i_vx_data      register-file combinational read data
//   o_vx_en        register-file write enable
//   o_vx_data      register-file write data
//   o_i_en         I write enable
//   o_i_data       new I value
//   o_mem_addr     RAM address
//   o_mem_we       RAM write enable
//   o_mem_wdata    RAM write data
//   i_mem_rdata    RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module reg_mem_transfer #(
  parameter bit INCR_I = 1'b1,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_load,
  input  logic [3:0]        i_x,
  input  logic [15:0]       i_i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_vx_addr,
  input  logic [7:0]        i_vx_data,
  output logic              o_vx_en,
  output logic [7:0]        o_vx_data,
  output logic              o_i_en,
  output logic [15:0]       o_i_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_STORE     = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_LOAD_TAIL = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [15:0]       base_q, base_d;
  logic [3:0]        last_q, last_d;
  logic [3:0]        n_q, n_d;
  logic [ADDR_W-1:0] cur_addr;

  // Only the low ADDR_W bits of I address memory; the add wraps silently.
  assign cur_addr = base_q[ADDR_W-1:0] + ADDR_W'(n_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    last_d  = last_q;
    n_d     = n_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          base_d  = i_i_data;
          last_d  = i_x;
          n_d     = 4'd0;
          state_d = i_load ? ST_LOAD : ST_STORE;
        end
      end
      ST_STORE: begin
        if (n_q == last_q) begin
          state_d = ST_DONE;
        end else begin
          n_d = n_q + 4'd1;
        end
      end
      ST_LOAD: begin
        // The last read still needs its write-back, which happens in LOAD_TAIL.
        if (n_q == last_q) begin
          state_d = ST_LOAD_TAIL;
        end else begin
          n_d = n_q + 4'd1;
        end
      end
      ST_LOAD_TAIL: state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= 16'd0;
      last_q  <= 4'd0;
      n_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      last_q  <= last_d;
      n_q     <= n_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. Everything is a function of the current state so that a
  // reset lands the outputs at zero in the very next cycle. Idle outputs are
  // held at zero to keep them stable.
  // -------------------------------------------------------------------------
  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_done      = 1'b0;
    o_vx_addr   = 4'd0;
    o_vx_en     = 1'b0;
    o_vx_data   = 8'd0;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = 8'd0;
    case (state_q)
      ST_STORE: begin
        o_vx_addr   = n_q;
        o_mem_addr  = cur_addr;
        o_mem_we    = 1'b1;
        o_mem_wdata = i_vx_data;
      end
      ST_LOAD: begin
        o_mem_addr = cur_addr;
        // Read data lags the address by one cycle, so the write-back trails
        // the read index by one; the first LOAD cycle has nothing to write.
        if (n_q != 4'd0) begin
          o_vx_en   = 1'b1;
          o_vx_addr = n_q - 4'd1;
          o_vx_data = i_mem_rdata;
        end
      end
      ST_LOAD_TAIL: begin
        o_vx_en   = 1'b1;
        o_vx_addr = last_q;
        o_vx_data = i_mem_rdata;
      end
      ST_DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // I update uses full 16-bit arithmetic, independent of ADDR_W.
  if (INCR_I) begin : g_incr_i
    assign o_i_en   = (state_q == ST_DONE);
    assign o_i_data = (state_q == ST_DONE) ? (base_q + {12'd0, last_q} + 16'd1) : 16'd0;
  end else begin : g_keep_i
    assign o_i_en   = 1'b0;
    assign o_i_data = 16'd0;
  end

endmodule

// File: tb/tb_reg_mem_transfer.sv
module tb_reg_mem_transfer;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_start, i_load;
  logic [3:0]    i_x;
  logic [15:0]   i_i_data;

  // main instance (INCR_I = 1)
  logic          o_busy, o_done, o_vx_en, o_i_en, o_mem_we;
  logic [3:0]    o_vx_addr;
  logic [7:0]    o_vx_data, o_mem_wdata, i_vx_data, i_mem_rdata;
  logic [15:0]   o_i_data;
  logic [AW-1:0] o_mem_addr;

  // second instance (INCR_I = 0), same stimulus, read-only view of the env
  logic          b0, d0, ve0, ie0, we0;
  logic [3:0]    va0;
  logic [7:0]    vd0, wd0, vxd0, mrd0;
  logic [15:0]   id0;
  logic [AW-1:0] ma0;

  reg_mem_transfer #(.INCR_I(1'b1), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_load(i_load), .i_x(i_x),
    .i_i_data(i_i_data), .o_busy(o_busy), .o_done(o_done), .o_vx_addr(o_vx_addr),
    .i_vx_data(i_vx_data), .o_vx_en(o_vx_en), .o_vx_data(o_vx_data), .o_i_en(o_i_en),
    .o_i_data(o_i_data), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  reg_mem_transfer #(.INCR_I(1'b0), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_load(i_load), .i_x(i_x),
    .i_i_data(i_i_data), .o_busy(b0), .o_done(d0), .o_vx_addr(va0),
    .i_vx_data(vxd0), .o_vx_en(ve0), .o_vx_data(vd0), .o_i_en(ie0),
    .o_i_data(id0), .o_mem_addr(ma0), .o_mem_we(we0),
    .o_mem_wdata(wd0), .i_mem_rdata(mrd0)
  );

  // environment: register file, RAM, I register (written by main DUT only)
  logic [7:0]  mem [4096];
  logic [7:0]  rf  [16];
  logic [15:0] ireg;
  assign i_vx_data = rf[o_vx_addr];
  assign vxd0      = rf[va0];

  // behavioural model state
  logic [7:0]  m_mem  [4096];
  logic [7:0]  m_regs [16];
  logic [15:0] m_i;
  logic        m_active;
  int          m_k;
  logic [15:0] m_base;
  int          m_last;
  logic        m_dir;

  // backdoor preset requests
  logic        bk_clear, bk_rf_we, bk_mem_we, bk_i_we;
  logic [11:0] bk_addr;
  logic [3:0]  bk_idx;
  logic [7:0]  bk_val;
  logic [15:0] bk_i;

  int checks, failures;
  bit chk_en;

  function automatic logic [11:0] maddr(input logic [15:0] b, input int off);
    logic [31:0] ov;
    logic [11:0] o;
    ov = off;
    o  = b[11:0] + ov[11:0];
    return o;
  endfunction

  function automatic int lat_of(input logic dir, input int last);
    return dir ? last + 3 : last + 2;
  endfunction

  // environment + model, advanced together on the clock
  always @(posedge clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
    mrd0        <= mem[ma0];
    if (o_vx_en) rf[o_vx_addr] <= o_vx_data;
    if (o_i_en) ireg <= o_i_data;

    if (bk_clear) begin
      for (int a = 0; a < 4096; a++) begin
        mem[a]   <= 8'h00;
        m_mem[a] <= 8'h00;
      end
      for (int r = 0; r < 16; r++) begin
        rf[r]     <= 8'h00;
        m_regs[r] <= 8'h00;
      end
    end
    if (bk_rf_we) begin
      rf[bk_idx]     <= bk_val;
      m_regs[bk_idx] <= bk_val;
    end
    if (bk_mem_we) begin
      mem[bk_addr]   <= bk_val;
      m_mem[bk_addr] <= bk_val;
    end
    if (bk_i_we) begin
      ireg <= bk_i;
      m_i  <= bk_i;
    end

    // effects of the cycle that is ending
    if (m_active) begin
      if (!m_dir && m_k <= m_last + 1)
        m_mem[maddr(m_base, m_k - 1)] <= m_regs[4'(m_k - 1)];
      if (m_dir && m_k >= 2 && m_k <= m_last + 2)
        m_regs[4'(m_k - 2)] <= m_mem[maddr(m_base, m_k - 2)];
      if (m_k == lat_of(m_dir, m_last))
        m_i <= m_base + 16'(m_last) + 16'd1;
    end

    if (rst) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (m_k == lat_of(m_dir, m_last)) m_active <= 1'b0;
      else m_k <= m_k + 1;
    end else if (i_start) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_base   <= i_i_data;
      m_last   <= int'(i_x);
      m_dir    <= i_load;
    end
  end

  function automatic logic [52:0] obs_main();
    return {o_busy, o_done, o_vx_en, o_mem_we, o_i_en, o_vx_addr, o_vx_data,
            o_mem_addr, o_mem_wdata, o_i_data};
  endfunction

  function automatic logic [52:0] obs_zero();
    return {b0, d0, ve0, we0, ie0, va0, vd0, ma0, wd0, id0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model timing rules.
  // Layout: busy done vx_en we i_en | vx_addr | vx_data | mem_addr | wdata | i_data
  task automatic cycle_compare();
    logic [52:0] e, m, e0, m0, o, o0;
    e = '0;
    m = {5'b11111, 48'd0};
    if (m_active) begin
      e[52] = 1'b1;
      if (!m_dir) begin
        if (m_k <= m_last + 1) begin
          e[49]    = 1'b1;
          e[47:44] = 4'(m_k - 1);
          e[35:24] = maddr(m_base, m_k - 1);
          e[23:16] = m_regs[4'(m_k - 1)];
          m[47:44] = 4'hF;
          m[35:24] = 12'hFFF;
          m[23:16] = 8'hFF;
        end
      end else begin
        if (m_k <= m_last + 1) begin
          e[35:24] = maddr(m_base, m_k - 1);
          m[35:24] = 12'hFFF;
        end
        if (m_k >= 2 && m_k <= m_last + 2) begin
          e[50]    = 1'b1;
          e[47:44] = 4'(m_k - 2);
          e[43:36] = m_mem[maddr(m_base, m_k - 2)];
          m[47:44] = 4'hF;
          m[43:36] = 8'hFF;
        end
      end
      if (m_k == lat_of(m_dir, m_last)) begin
        e[51]   = 1'b1;
        e[48]   = 1'b1;
        e[15:0] = m_base + 16'(m_last) + 16'd1;
        m[15:0] = 16'hFFFF;
      end
    end
    e0 = e;  e0[48] = 1'b0;
    m0 = m;  m0[15:0] = 16'd0;
    o  = obs_main();
    o0 = obs_zero();
    checks++;
    if ((o & m) !== (e & m)) begin
      failures++;
      $display("FAIL cycle_main t=%0t k=%0d got=%h exp=%h mask=%h", $time, m_k, o, e, m);
    end
    checks++;
    if ((o0 & m0) !== (e0 & m0)) begin
      failures++;
      $display("FAIL cycle_incr0 t=%0t k=%0d got=%h exp=%h mask=%h", $time, m_k, o0, e0, m0);
    end
  endtask

  task automatic poke_rf(input logic [3:0] idx, input logic [7:0] v);
    bk_rf_we = 1'b1; bk_idx = idx; bk_val = v;
    @(negedge clk);
    bk_rf_we = 1'b0;
  endtask

  task automatic poke_mem(input logic [11:0] a, input logic [7:0] v);
    bk_mem_we = 1'b1; bk_addr = a; bk_val = v;
    @(negedge clk);
    bk_mem_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic start_txn(input logic ld, input logic [3:0] x, input logic [15:0] base);
    i_start = 1'b1; i_load = ld; i_x = x; i_i_data = base;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Returns the cycle number of o_done, ending at the negedge after DONE.
  task automatic wait_done(input bit sel0, input bit stray, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 1;
    while (!seen && cyc <= 40) begin
      if (sel0 ? d0 : o_done) begin
        seen = 1'b1;
      end else begin
        if (stray) begin
          i_start  = ($urandom_range(0, 2) == 0);
          i_load   = 1'($urandom);
          i_x      = 4'($urandom);
          i_i_data = 16'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    i_start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=none exp=done within 40 cycles");
    end
    @(negedge clk);
  endtask

  task automatic final_state_check(input string nm);
    int bad_r, bad_m;
    bad_r = -1;
    bad_m = -1;
    for (int r = 0; r < 16; r++) if (bad_r < 0 && rf[r] !== m_regs[r]) bad_r = r;
    for (int a = 0; a < 4096; a++) if (bad_m < 0 && mem[a] !== m_mem[a]) bad_m = a;
    checks++;
    if (bad_r >= 0) begin
      failures++;
      $display("FAIL %s_regs V%0d got=%h exp=%h", nm, bad_r, rf[bad_r], m_regs[bad_r]);
    end
    checks++;
    if (bad_m >= 0) begin
      failures++;
      $display("FAIL %s_mem addr=%h got=%h exp=%h", nm, bad_m, mem[bad_m], m_mem[bad_m]);
    end
    chk({nm, "_I"}, 64'(ireg), 64'(m_i));
  endtask

  initial begin
    int cyc, ntx;
    logic ld;
    logic [3:0] x;
    logic [15:0] base;
    checks = 0; failures = 0; chk_en = 1'b0; ntx = 0;
    rst = 1'b1; i_start = 1'b0; i_load = 1'b0; i_x = 4'd0; i_i_data = 16'd0;
    bk_clear = 1'b1; bk_rf_we = 1'b0; bk_mem_we = 1'b0; bk_i_we = 1'b1;
    bk_addr = 12'd0; bk_idx = 4'd0; bk_val = 8'd0; bk_i = 16'd0;
    @(negedge clk);
    bk_clear = 1'b0; bk_i_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_main", 64'(obs_main()), 64'd0);
    chk("reset_incr0", 64'(obs_zero()), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) cycle_compare();
      end
    join_none

    // store x=0 at 0x300
    poke_rf(4'd0, 8'hAB);
    start_txn(1'b0, 4'd0, 16'h0300);
    wait_done(1'b0, 1'b0, cyc);
    $display("txn %0d store x=0 I=0300 done_cycle=%0d", ntx++, cyc);
    chk("A_done_cycle", 64'(cyc), 64'd2);
    chk("A_mem300", 64'(mem[12'h300]), 64'hAB);
    chk("A_I", 64'(ireg), 64'h0301);
    final_state_check("A");

    // store x=15 at 0x200
    for (int n = 0; n < 16; n++) poke_rf(4'(n), 8'(8'h10 + n));
    start_txn(1'b0, 4'd15, 16'h0200);
    wait_done(1'b0, 1'b0, cyc);
    $display("txn %0d store x=15 I=0200 done_cycle=%0d", ntx++, cyc);
    chk("B_done_cycle", 64'(cyc), 64'd17);
    chk("B_mem200", 64'(mem[12'h200]), 64'h10);
    chk("B_mem20F", 64'(mem[12'h20F]), 64'h1F);
    chk("B_I", 64'(ireg), 64'h0210);
    final_state_check("B");

    // load x=3 from 0x400
    poke_mem(12'h400, 8'hDE); poke_mem(12'h401, 8'hAD);
    poke_mem(12'h402, 8'hBE); poke_mem(12'h403, 8'hEF);
    poke_rf(4'd4, 8'h55);
    start_txn(1'b1, 4'd3, 16'h0400);
    wait_done(1'b0, 1'b0, cyc);
    $display("txn %0d load x=3 I=0400 done_cycle=%0d", ntx++, cyc);
    chk("C_done_cycle", 64'(cyc), 64'd6);
    chk("C_V0V3", 64'({rf[0], rf[1], rf[2], rf[3]}), 64'hDEADBEEF);
    chk("C_V4_kept", 64'(rf[4]), 64'h55);
    chk("C_I", 64'(ireg), 64'h0404);
    final_state_check("C");

    // store wrapping past the top of memory
    for (int n = 0; n < 4; n++) poke_rf(4'(n), 8'(8'hA0 + n));
    start_txn(1'b0, 4'd3, 16'h0FFE);
    wait_done(1'b0, 1'b0, cyc);
    $display("txn %0d store x=3 I=0FFE done_cycle=%0d", ntx++, cyc);
    chk("W_wrap_bytes", 64'({mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]}), 64'hA0A1A2A3);
    chk("W_I", 64'(ireg), 64'h1002);
    final_state_check("W");

    // stray start while busy, then reset in cycle 3 of a load x=7
    start_txn(1'b1, 4'd7, 16'h0500);
    @(negedge clk);
    i_start = 1'b1; i_load = 1'b0; i_x = 4'd2; i_i_data = 16'h0700;
    @(negedge clk);
    i_start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("txn %0d load x=7 I=0500 aborted by reset in cycle 3", ntx++);
    chk("R_busy_c4", 64'(o_busy), 64'd0);
    chk("R_en_c4", 64'({o_vx_en, o_mem_we, o_i_en, o_done}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("R_quiet", 64'({o_busy, o_done}), 64'd0);
    end
    chk("R_I_kept", 64'(ireg), 64'h1002);
    final_state_check("R");
    start_txn(1'b0, 4'd1, 16'h0600);
    wait_done(1'b0, 1'b0, cyc);
    $display("txn %0d store x=1 I=0600 done_cycle=%0d", ntx++, cyc);
    chk("R2_done_cycle", 64'(cyc), 64'd3);
    chk("R2_I", 64'(ireg), 64'h0602);
    final_state_check("R2");

    // reset and start in the same cycle: start dropped
    i_start = 1'b1; i_load = 1'b1; i_x = 4'd5; i_i_data = 16'h0800; rst = 1'b1;
    @(negedge clk);
    i_start = 1'b0; rst = 1'b0;
    chk("S_busy_a", 64'(o_busy), 64'd0);
    @(negedge clk);
    chk("S_busy_b", 64'(o_busy), 64'd0);

    // load x=2, timed on the INCR_I=0 instance
    poke_mem(12'h900, 8'h11); poke_mem(12'h901, 8'h22); poke_mem(12'h902, 8'h33);
    start_txn(1'b1, 4'd2, 16'h0900);
    wait_done(1'b1, 1'b0, cyc);
    $display("txn %0d load x=2 I=0900 (incr0) done_cycle=%0d", ntx++, cyc);
    chk("N_done_cycle", 64'(cyc), 64'd5);
    chk("N_V0V2", 64'({rf[0], rf[1], rf[2]}), 64'h112233);
    final_state_check("N");

    // randomized transactions, back-to-back or with gaps, stray starts
    for (int t = 0; t < 40; t++) begin
      ld   = 1'($urandom);
      x    = 4'($urandom_range(0, 15));
      base = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j <= int'(x); j++)
          if ($urandom_range(0, 1) == 1) begin
            if (ld) poke_mem(maddr(base, j), 8'($urandom));
            else poke_rf(4'(j), 8'($urandom));
          end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_txn(ld, x, base);
      wait_done(1'b0, 1'b1, cyc);
      $display("txn %0d %s x=%0d I=%h done_cycle=%0d", ntx++, ld ? "load" : "store", x, base, cyc);
      chk("rand_done_cycle", 64'(cyc), 64'(lat_of(ld, int'(x))));
      final_state_check("rand");
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
